mux8_rr_collector: RTL and testbench

//  8-to-1 collector: the gathering counterpart of dmux8 (which fans one input out to 8 by addr).

---
 rtl/mux8_rr_collector.sv | 86 ++++++++
 tb/tb_mux8_rr_collector.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_collector.sv
// mux8_rr_collector
//   Merges eight valid/ready source channels onto one registered output
//   stream with round-robin arbitration. The winning channel number is
//   carried alongside the word on out_addr.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel request, bit i = channel i has a word
//   in_data    channel i word at [i*WIDTH +: WIDTH]
//   in_ready   one-hot (or zero) accept strobe to the channels
//   out_valid  output register holds a word
//   out_data   registered word
//   out_addr   channel index that supplied out_data
//   out_ready  consumer accepts out_data this cycle
module mux8_rr_collector #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_addr,
  input  logic               out_ready
);

  logic [2:0]       last;
  logic [2:0]       grant;
  logic [2:0]       idx;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  // Register is free when empty or being drained this same cycle.
  assign load = ~out_valid | out_ready;

  // Search starts one past the previous winner and wraps 7 -> 0; the
  // 3-bit sum wraps naturally, and k=8 lands back on last itself so a
  // lone requester is always re-granted.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = last + k[2:0];
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (grant == i[2:0]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by rst_n so no source sees an accept while reset is held.
  assign in_ready = (rst_n && load && found) ? (8'b1 << grant) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      last      <= 3'd7;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_addr  <= grant;
        last      <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux8_rr_collector.sv
// tb_mux8_rr_collector
//   Directed bench for mux8_rr_collector. Sources are per-channel word
//   queues; a behavioural model tracks the expected output register and
//   round-robin pointer, and a per-channel scoreboard checks every
//   consumed word in order.
module tb_mux8_rr_collector;

  logic         clk;
  logic         rst_n;
  logic [7:0]   in_valid;
  logic [127:0] in_data;
  logic [7:0]   in_ready;
  logic         out_valid;
  logic [15:0]  out_data;
  logic [2:0]   out_addr;
  logic         out_ready;

  mux8_rr_collector #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] src_q [8][$];
  logic [15:0] exp_q [8][$];
  int          order_log [$];

  // model state
  logic        m_valid;
  logic [15:0] m_data;
  logic [2:0]  m_addr;
  int          m_last;

  // values sampled at negedge, applied at the following posedge
  logic        acc_v;
  int          acc_g;
  logic [15:0] acc_w;
  logic        ld_c;
  logic        cons_v;
  logic [2:0]  cons_a;
  logic [15:0] cons_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout/empty expected=event at %0t", name, $time);
  endtask

  function automatic int pick(input int last, input logic [7:0] v);
    int r;
    r = -1;
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (last + k) % 8;
      if (r < 0 && v[c]) r = c;
    end
    return r;
  endfunction

  function automatic bit srcs_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < 8; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < 8; i++) begin
      if (src_q[i].size() != 0) begin
        in_valid[i] = 1'b1;
        in_data[i*16 +: 16] = src_q[i][0];
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*16 +: 16] = 16'h0000;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(srcs_empty() && !m_valid) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail_now("wait_idle");
  endtask

  // Compare process: all inputs and registers are stable at negedge.
  always @(negedge clk) begin
    int g;
    logic [7:0] exp_rdy;
    g = pick(m_last, in_valid);
    ld_c = !m_valid || out_ready;
    exp_rdy = (rst_n && ld_c && g >= 0) ? 8'(1 << g) : 8'h00;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("in_ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_addr", 32'(out_addr), 32'(m_addr));
    check("out_data", 32'(out_data), 32'(m_data));
    acc_v = exp_rdy != 8'h00;
    acc_g = g;
    acc_w = (g >= 0) ? in_data[g*16 +: 16] : 16'h0000;
    cons_v = rst_n && m_valid && out_ready;
    cons_a = out_addr;
    cons_d = out_data;
  end

  // Model and scoreboard update on the clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 16'h0000;
      m_addr  = 3'd0;
      m_last  = 7;
      acc_v   = 1'b0;
      cons_v  = 1'b0;
      for (int i = 0; i < 8; i++) exp_q[i].delete();
    end else begin
      if (cons_v) begin
        if (exp_q[cons_a].size() == 0) begin
          fail_now("scoreboard_empty");
        end else begin
          logic [15:0] w;
          w = exp_q[cons_a].pop_front();
          check("scoreboard_data", 32'(cons_d), 32'(w));
        end
        order_log.push_back(int'(cons_a));
      end
      if (acc_v) begin
        void'(src_q[acc_g].pop_front());
        exp_q[acc_g].push_back(acc_w);
        m_valid = 1'b1;
        m_data  = acc_w;
        m_addr  = 3'(acc_g);
        m_last  = acc_g;
      end else if (ld_c) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    drive_inputs();
  end

  initial begin
    int rem;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 8'h00;
    in_data   = '0;

    // Reset with a pending request: nothing accepted, outputs cleared.
    src_q[3].push_back(16'h3333);
    drive_inputs();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("first_grant_ch3", 32'(in_ready), 32'h08);
    wait_idle(20);
    check("idle_hold_addr", 32'(out_addr), 32'd3);
    check("idle_hold_data", 32'(out_data), 32'h3333);

    // Single channel 5.
    tick();
    src_q[5].push_back(16'hBEEF);
    drive_inputs();
    @(negedge clk);
    check("single_in_ready", 32'(in_ready), 32'h20);
    tick();
    @(negedge clk);
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_out_addr", 32'(out_addr), 32'd5);
    check("single_out_data", 32'(out_data), 32'hBEEF);
    tick();
    for (int i = 0; i < 3; i++) src_q[5].push_back(16'hBE00 + 16'(i));
    drive_inputs();
    wait_idle(20);

    // All channels request; pointer first parked at 7.
    src_q[7].push_back(16'h7777);
    drive_inputs();
    wait_idle(20);
    order_log.delete();
    for (int i = 0; i < 8; i++) begin
      src_q[i].push_back(16'h0100 + 16'(i));
      src_q[i].push_back(16'h0200 + 16'(i));
    end
    drive_inputs();
    wait_idle(40);
    check("all_count", 32'(order_log.size()), 32'd16);
    if (order_log.size() == 16)
      for (int k = 0; k < 16; k++) check("all_order", 32'(order_log[k]), 32'(k % 8));

    // Backpressure.
    out_ready = 1'b0;
    src_q[1].push_back(16'hA001);
    src_q[2].push_back(16'hA002);
    src_q[4].push_back(16'hA004);
    drive_inputs();
    @(negedge clk);
    check("bp_first_grant", 32'(in_ready), 32'h02);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_addr", 32'(out_addr), 32'd1);
      check("bp_data", 32'(out_data), 32'hA001);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 32'(in_ready), 32'h04);
    wait_idle(20);

    // Wrap from last=6 with channels 0 and 6 requesting.
    src_q[6].push_back(16'hC006);
    drive_inputs();
    wait_idle(20);
    order_log.delete();
    src_q[0].push_back(16'hD000);
    src_q[0].push_back(16'hD001);
    src_q[6].push_back(16'hD006);
    drive_inputs();
    wait_idle(20);
    check("wrap_count", 32'(order_log.size()), 32'd3);
    if (order_log.size() == 3) begin
      check("wrap_0", 32'(order_log[0]), 32'd0);
      check("wrap_1", 32'(order_log[1]), 32'd6);
      check("wrap_2", 32'(order_log[2]), 32'd0);
    end

    // Idle: data held, pointer unchanged (last=0 so ch1 beats ch6).
    @(negedge clk);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_data", 32'(out_data), 32'hD001);
    check("idle_addr", 32'(out_addr), 32'd0);
    tick();
    src_q[6].push_back(16'hE006);
    src_q[1].push_back(16'hE001);
    drive_inputs();
    @(negedge clk);
    check("idle_last_kept", 32'(in_ready), 32'h02);
    wait_idle(20);

    // Reset mid-transfer.
    out_ready = 1'b0;
    src_q[2].push_back(16'hF002);
    drive_inputs();
    @(posedge clk);
    #3;
    for (int i = 0; i < 8; i++) src_q[i].delete();
    drive_inputs();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    src_q[5].push_back(16'h1005);
    src_q[0].push_back(16'h1000);
    drive_inputs();
    @(negedge clk);
    check("post_rst_ch0_first", 32'(in_ready), 32'h01);
    wait_idle(20);

    rem = 0;
    for (int i = 0; i < 8; i++) rem += exp_q[i].size();
    check("scoreboard_leftover", 32'(rem), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
